exe_stage_muldiv: RTL and testbench

- Execute stage sitting directly downstream of the ID-to-EXE pipeline register, feeding the EXE-to-MEM register.
- Performs single-cycle ALU operations combinationally.
- Adds an iterative 32-cycle unsigned multiplier/divider that stalls the front of the pipeline while busy.
- Forwarding muxes for both operands and the store value are inside this block.

---
 rtl/exe_stage_muldiv.sv | 195 +++++++++++++++++++
 tb/tb_exe_stage_muldiv.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_muldiv.sv
// Execute stage with combinational ALU, operand/store forwarding and an
// iterative 32-cycle unsigned multiplier/divider that stalls the front of the
// pipeline while it works. A multi-cycle op occupies one IDLE issue cycle,
// 32 BUSY cycles and one DONE cycle in which the result leaves the stage.
module exe_stage_muldiv #(
   parameter int                  WORD_LEN     = 32,
   parameter int                  REG_ADDR_LEN = 5,
   parameter int                  CMD_LEN      = 4,
   parameter logic [CMD_LEN-1:0]  CMD_MULU     = 4'b1011,
   parameter logic [CMD_LEN-1:0]  CMD_DIVU     = 4'b1100
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CMD_LEN-1:0]      EXE_CMD,
   input  logic [WORD_LEN-1:0]     val1,
   input  logic [WORD_LEN-1:0]     val2,
   input  logic [WORD_LEN-1:0]     ST_value,
   input  logic [REG_ADDR_LEN-1:0] dest,
   input  logic                    WB_EN,
   input  logic                    MEM_R_EN,
   input  logic                    MEM_W_EN,
   input  logic [1:0]              val1_sel,
   input  logic [1:0]              val2_sel,
   input  logic [1:0]              st_sel,
   input  logic [WORD_LEN-1:0]     mem_fwd_value,
   input  logic [WORD_LEN-1:0]     wb_fwd_value,
   output logic [WORD_LEN-1:0]     ALU_result,
   output logic [WORD_LEN-1:0]     ST_value_out,
   output logic [REG_ADDR_LEN-1:0] dest_out,
   output logic                    WB_EN_out,
   output logic                    MEM_R_EN_out,
   output logic                    MEM_W_EN_out,
   output logic                    stall,
   output logic                    md_busy
);

   // ALU command encodings shared with the decode stage
   localparam logic [CMD_LEN-1:0] CMD_ADD = 4'b0000;
   localparam logic [CMD_LEN-1:0] CMD_SUB = 4'b0010;
   localparam logic [CMD_LEN-1:0] CMD_AND = 4'b0100;
   localparam logic [CMD_LEN-1:0] CMD_OR  = 4'b0101;
   localparam logic [CMD_LEN-1:0] CMD_NOR = 4'b0110;
   localparam logic [CMD_LEN-1:0] CMD_XOR = 4'b0111;
   localparam logic [CMD_LEN-1:0] CMD_SLL = 4'b1000;
   localparam logic [CMD_LEN-1:0] CMD_SRA = 4'b1001;
   localparam logic [CMD_LEN-1:0] CMD_SRL = 4'b1010;

   localparam int                CNT_W    = $clog2(WORD_LEN);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_t;

   md_state_t           r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_is_div;
   logic [WORD_LEN-1:0] r_op_a;   // multiplicand (shifted left) or divisor
   logic [WORD_LEN-1:0] r_op_b;   // multiplier (shifted right) or dividend/quotient
   logic [WORD_LEN-1:0] r_acc;    // product accumulator or partial remainder

   logic [WORD_LEN-1:0] w_op1;
   logic [WORD_LEN-1:0] w_op2;
   logic [WORD_LEN-1:0] w_st;
   logic [WORD_LEN-1:0] w_alu;
   logic                w_is_md;
   logic                w_is_divu;
   logic [WORD_LEN-1:0] w_mul_acc_nxt;
   logic [WORD_LEN:0]   w_div_diff;
   logic                w_div_ok;
   logic [WORD_LEN-1:0] w_div_rem_sh;
   logic [WORD_LEN-1:0] w_md_result;

   // Select 1 takes the MEM-stage ALU result, 2 the WB value, 0/3 the register
   function automatic logic [WORD_LEN-1:0] fwd_mux(
      input logic [1:0]          sel,
      input logic [WORD_LEN-1:0] reg_v,
      input logic [WORD_LEN-1:0] mem_v,
      input logic [WORD_LEN-1:0] wb_v
   );
      case (sel)
         2'd1:    return mem_v;
         2'd2:    return wb_v;
         default: return reg_v;
      endcase
   endfunction

   assign w_op1 = fwd_mux(val1_sel, val1,     mem_fwd_value, wb_fwd_value);
   assign w_op2 = fwd_mux(val2_sel, val2,     mem_fwd_value, wb_fwd_value);
   assign w_st  = fwd_mux(st_sel,   ST_value, mem_fwd_value, wb_fwd_value);

   assign w_is_divu = (EXE_CMD == CMD_DIVU);
   assign w_is_md   = (EXE_CMD == CMD_MULU) || w_is_divu;

   // Single-cycle ALU on the forwarded operands
   always_comb begin
      // NOTE: default first so every path assigns w_alu and no latch is inferred.
      w_alu = '0;
      case (EXE_CMD)
         CMD_ADD: w_alu = w_op1 + w_op2;
         CMD_SUB: w_alu = w_op1 - w_op2;
         CMD_AND: w_alu = w_op1 & w_op2;
         CMD_OR:  w_alu = w_op1 | w_op2;
         CMD_NOR: w_alu = ~(w_op1 | w_op2);
         CMD_XOR: w_alu = w_op1 ^ w_op2;
         CMD_SLL: w_alu = w_op1 << w_op2[4:0];
         CMD_SRA: w_alu = $signed(w_op1) >>> w_op2[4:0];
         CMD_SRL: w_alu = w_op1 >> w_op2[4:0];
         default: w_alu = '0;
      endcase
   end

   // One shift-add step: add the multiplicand when the current multiplier LSB is set
   assign w_mul_acc_nxt = r_acc + (r_op_b[0] ? r_op_a : '0);

   // One restoring-divide step: shift the next dividend bit into the remainder
   // and try to subtract the divisor; a clear borrow bit means the bit is 1
   assign w_div_diff   = {r_acc, r_op_b[WORD_LEN-1]} - {1'b0, r_op_a};
   assign w_div_ok     = ~w_div_diff[WORD_LEN];
   assign w_div_rem_sh = {r_acc[WORD_LEN-2:0], r_op_b[WORD_LEN-1]};

   assign w_md_result = r_is_div ? r_op_b : r_acc;

   // Multiply/divide sequencer: issue capture, 32 iterations, one result cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_acc    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (w_is_md) begin
                  r_cnt    <= '0;
                  r_acc    <= '0;
                  r_is_div <= w_is_divu;
                  if (w_is_divu) begin
                     r_op_a <= w_op2;
                     if (w_op2 == '0) begin
                        r_op_b  <= '1;
                        r_state <= S_DONE;
                     end else begin
                        r_op_b  <= w_op1;
                        r_state <= S_BUSY;
                     end
                  end else begin
                     r_op_a  <= w_op1;
                     r_op_b  <= w_op2;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_is_div) begin
                  r_op_b <= {r_op_b[WORD_LEN-2:0], w_div_ok};
                  r_acc  <= w_div_ok ? w_div_diff[WORD_LEN-1:0] : w_div_rem_sh;
               end else begin
                  r_acc  <= w_mul_acc_nxt;
                  r_op_a <= r_op_a << 1;
                  r_op_b <= r_op_b >> 1;
               end
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Stall while issuing or iterating; reset drops it without waiting for a clock
   assign stall   = rst && (((r_state == S_IDLE) && w_is_md) || (r_state == S_BUSY));
   assign md_busy = (r_state == S_BUSY);

   // Outputs toward the EXE-to-MEM register; stalled cycles become bubbles
   assign ALU_result   = (r_state == S_DONE) ? w_md_result : w_alu;
   assign ST_value_out = w_st;
   assign dest_out     = dest;
   assign WB_EN_out    = WB_EN    && !stall;
   assign MEM_R_EN_out = MEM_R_EN && !stall;
   assign MEM_W_EN_out = MEM_W_EN && !stall;

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Self-checking bench for exe_stage_muldiv: expected results are pushed to a
// scoreboard queue at issue and popped when the stage releases the stall.
module tb_exe_stage_muldiv;

   localparam logic [3:0] C_ADD  = 4'b0000;
   localparam logic [3:0] C_SUB  = 4'b0010;
   localparam logic [3:0] C_AND  = 4'b0100;
   localparam logic [3:0] C_OR   = 4'b0101;
   localparam logic [3:0] C_NOR  = 4'b0110;
   localparam logic [3:0] C_XOR  = 4'b0111;
   localparam logic [3:0] C_SLL  = 4'b1000;
   localparam logic [3:0] C_SRA  = 4'b1001;
   localparam logic [3:0] C_SRL  = 4'b1010;
   localparam logic [3:0] C_MULU = 4'b1011;
   localparam logic [3:0] C_DIVU = 4'b1100;
   localparam logic [3:0] C_NOP  = 4'b1111;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  EXE_CMD;
   logic [31:0] val1, val2, ST_value;
   logic [4:0]  dest;
   logic        WB_EN, MEM_R_EN, MEM_W_EN;
   logic [1:0]  val1_sel, val2_sel, st_sel;
   logic [31:0] mem_fwd_value, wb_fwd_value;
   logic [31:0] ALU_result, ST_value_out;
   logic [4:0]  dest_out;
   logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
   logic        stall, md_busy;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   exe_stage_muldiv dut (
      .clk           (clk),
      .rst           (rst),
      .EXE_CMD       (EXE_CMD),
      .val1          (val1),
      .val2          (val2),
      .ST_value      (ST_value),
      .dest          (dest),
      .WB_EN         (WB_EN),
      .MEM_R_EN      (MEM_R_EN),
      .MEM_W_EN      (MEM_W_EN),
      .val1_sel      (val1_sel),
      .val2_sel      (val2_sel),
      .st_sel        (st_sel),
      .mem_fwd_value (mem_fwd_value),
      .wb_fwd_value  (wb_fwd_value),
      .ALU_result    (ALU_result),
      .ST_value_out  (ST_value_out),
      .dest_out      (dest_out),
      .WB_EN_out     (WB_EN_out),
      .MEM_R_EN_out  (MEM_R_EN_out),
      .MEM_W_EN_out  (MEM_W_EN_out),
      .stall         (stall),
      .md_busy       (md_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] m, input logic [31:0] w);
      if (sel == 2'd1) return m;
      if (sel == 2'd2) return w;
      return r;
   endfunction

   function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b);
      case (cmd)
         C_ADD:   return a + b;
         C_SUB:   return a - b;
         C_AND:   return a & b;
         C_OR:    return a | b;
         C_NOR:   return ~(a | b);
         C_XOR:   return a ^ b;
         C_SLL:   return a << b[4:0];
         C_SRA:   return $signed(a) >>> b[4:0];
         C_SRL:   return a >> b[4:0];
         C_MULU:  return a * b;
         C_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic set_in(input logic [31:0] v1, input logic [31:0] v2,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] m, input logic [31:0] w);
      val1 = v1; val2 = v2; val1_sel = s1; val2_sel = s2;
      mem_fwd_value = m; wb_fwd_value = w;
   endtask

   // Called just after a rising edge with operands already set; holds the
   // instruction (as a frozen ID-to-EXE register would) until stall drops.
   task automatic issue(input logic [3:0] cmd, input int exp_stall,
                        input bit scramble, input string tag);
      logic [31:0] exp_st;
      logic [2:0]  exp_ctl;
      int          n_stall = 0;
      int          n_busy  = 0;
      int          n_bubble = 0;
      EXE_CMD = cmd;
      exp_q.push_back(model(cmd, fwd(val1_sel, val1, mem_fwd_value, wb_fwd_value),
                                 fwd(val2_sel, val2, mem_fwd_value, wb_fwd_value)));
      exp_st  = fwd(st_sel, ST_value, mem_fwd_value, wb_fwd_value);
      exp_ctl = {WB_EN, MEM_R_EN, MEM_W_EN};
      @(negedge clk);
      while (stall === 1'b1 && n_stall < 200) begin
         n_stall++;
         if (md_busy === 1'b1) n_busy++;
         if ({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out} !== 3'b000) n_bubble++;
         @(posedge clk);
         #1;
         if (scramble) begin
            mem_fwd_value = $urandom;
            wb_fwd_value  = $urandom;
         end
         @(negedge clk);
      end
      check({tag, "_stall_cycles"}, n_stall, exp_stall);
      check({tag, "_busy_cycles"}, n_busy, (exp_stall > 1) ? exp_stall - 1 : 0);
      check({tag, "_bubble"}, n_bubble, 0);
      check({tag, "_result"}, ALU_result, exp_q.pop_front());
      check({tag, "_ctl"}, {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}, exp_ctl);
      check({tag, "_dest"}, dest_out, dest);
      if (!scramble) check({tag, "_st"}, ST_value_out, exp_st);
      @(posedge clk);
      #1;
   endtask

   logic [3:0] alu_cmds [10] = '{C_ADD, C_SUB, C_AND, C_OR, C_NOR,
                                 C_XOR, C_SLL, C_SRA, C_SRL, C_NOP};

   initial begin
      // Reset held with a multi-cycle command present
      rst = 1'b0;
      EXE_CMD = C_MULU; dest = 5'd3; ST_value = 32'h1234_5678; st_sel = 2'd0;
      WB_EN = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      set_in(32'h0001_0003, 32'h0002_0005, 2'd0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_busy", md_busy, 1'b0);
      check("rst_wb_follow", WB_EN_out, 1'b1);
      #2 rst = 1'b1;
      @(negedge clk);
      check("rel_stall", stall, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rerst_stall", stall, 1'b0);
      check("rerst_busy", md_busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Add wrap-around and forwarded subtract
      set_in(32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 32'd0, 32'd0);
      issue(C_ADD, 0, 1'b0, "add_wrap");
      set_in(32'hDEAD_0000, 32'hBEEF_0000, 2'd1, 2'd2, 32'd7, 32'd5);
      dest = 5'd9; st_sel = 2'd2;
      issue(C_SUB, 0, 1'b0, "sub_fwd");

      // Random ALU sweep with random forwarding and control patterns
      for (int i = 0; i < 20; i++) begin
         set_in($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom, $urandom);
         ST_value = $urandom; st_sel = 2'($urandom_range(0, 3)); dest = 5'($urandom);
         {WB_EN, MEM_R_EN, MEM_W_EN} = 3'($urandom);
         issue(alu_cmds[i % 10], 0, 1'b0, $sformatf("alu%0d", i));
      end

      // Multiply from the directed example
      WB_EN = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; st_sel = 2'd0; dest = 5'd4;
      set_in(32'h0001_0003, 32'h0002_0005, 2'd0, 2'd0, 32'd0, 32'd0);
      issue(C_MULU, 33, 1'b0, "mulu");
      check("mulu_known", 32'h000B_000F, model(C_MULU, 32'h0001_0003, 32'h0002_0005));

      // Divide with a forwarded dividend that changes while busy, then divide by zero
      set_in(32'd0, 32'd7, 2'd1, 2'd0, 32'd100, 32'd0);
      issue(C_DIVU, 33, 1'b1, "divu_100_7");
      set_in(32'hCAFE_F00D, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
      issue(C_DIVU, 1, 1'b0, "divu_zero");

      // Random multi-cycle operations
      for (int i = 0; i < 3; i++) begin
         set_in($urandom, $urandom, 2'd0, 2'd2, 32'd0, $urandom);
         issue(C_MULU, 33, 1'b0, $sformatf("mulu_rnd%0d", i));
         set_in($urandom, 32'($urandom_range(1, 1 << (4 + 8 * i))), 2'd0, 2'd0, 32'd0, 32'd0);
         issue(C_DIVU, 33, 1'b0, $sformatf("divu_rnd%0d", i));
      end

      // Reset in the tenth BUSY cycle of a multiply
      set_in(32'h1234_5678, 32'h9ABC_DEF0, 2'd0, 2'd0, 32'd0, 32'd0);
      EXE_CMD = C_MULU;
      repeat (11) @(negedge clk);
      check("mid_busy", md_busy, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_stall", stall, 1'b0);
      check("mid_rst_busy", md_busy, 1'b0);
      check("mid_rst_wb", WB_EN_out, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_in(32'd40, 32'd2, 2'd0, 2'd0, 32'd0, 32'd0);
      issue(C_ADD, 0, 1'b0, "post_rst_add");
      set_in(32'd9, 32'd3, 2'd0, 2'd0, 32'd0, 32'd0);
      issue(C_DIVU, 33, 1'b0, "post_rst_div");

      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
